// File: rtl/bday_digit_scanner_pkg.sv
// Shared constants for the birthday digit scanner: seven-segment encodings
// and the default scan prescale.
package bday_digit_scanner_pkg;

    localparam int SCAN_DIV_DEFAULT = 4;

    localparam int NUM_POS = 8;
    localparam int CODE_W  = 4;
    localparam int SEG_W   = 7;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH    = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK   = 7'h00;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;

    // Position enable for a 3-bit scan index.
    function automatic logic [NUM_POS-1:0] pos_onehot(input logic [2:0] idx);
        pos_onehot = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to seven-segment decoder: 0-9 digits,
// 10-14 dash, 15 blank.
module seg7_decode
    import bday_digit_scanner_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            4'd10,
            4'd11,
            4'd12,
            4'd13,
            4'd14:   seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bday_digit_scanner.sv
// Eight-position multiplexed seven-segment driver with a write-side digit
// buffer and a frame-complete pulse once every position has been written.
module bday_digit_scanner
    import bday_digit_scanner_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    output logic [SEG_W-1:0]  seg,
    output logic [NUM_POS-1:0] an,
    output logic              frame_done
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [CODE_W-1:0]  buf_p0 [NUM_POS];
    logic [PRE_W-1:0]   pre_p0;
    logic [2:0]         idx_p0;
    logic [NUM_POS-1:0] mask_p0;

    logic [CODE_W-1:0]  cur_code;
    logic [SEG_W-1:0]   seg_dec;
    logic [NUM_POS-1:0] wr_bit;
    logic [NUM_POS-1:0] mask_set;
    logic               frame_full;
    logic               pre_wrap;

    assign cur_code   = buf_p0[idx_p0];
    assign pre_wrap   = (pre_p0 == PRE_LAST);
    assign wr_bit     = wr_en ? pos_onehot(wr_addr) : '0;
    assign mask_set   = mask_p0 | wr_bit;
    assign frame_full = &mask_set;

    seg7_decode u_dec (
        .code (cur_code),
        .seg  (seg_dec)
    );

    // Stage p0: digit buffer, free-running scan counters and written mask
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_POS; i++) begin
                buf_p0[i] <= CODE_BLANK;
            end
            pre_p0  <= '0;
            idx_p0  <= '0;
            mask_p0 <= '0;
        end else begin
            if (wr_en) begin
                buf_p0[wr_addr] <= wr_data;
            end
            if (pre_wrap) begin
                pre_p0 <= '0;
                idx_p0 <= idx_p0 + 3'd1;
            end else begin
                pre_p0 <= pre_p0 + PRE_W'(1);
            end
            // The completing write clears the mask in the same edge, so the
            // next write always starts a fresh frame.
            mask_p0 <= frame_full ? '0 : mask_set;
        end
    end

    // Stage p1: registered display drive and frame pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg        <= SEG_BLANK;
            an         <= 8'h01;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_dec;
            an         <= pos_onehot(idx_p0);
            frame_done <= frame_full;
        end
    end

endmodule

// File: tb/tb_bday_digit_scanner.sv
// Directed bench for bday_digit_scanner with a cycle-level reference model
// feeding an expected-output queue.
module tb_bday_digit_scanner;
    import bday_digit_scanner_pkg::*;

    localparam int SD = 4;

    logic       CLK;
    logic       RST;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [6:0] seg;
    logic [7:0] an;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    int fd_seen  = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] an;
        logic       fd;
    } exp_t;

    exp_t       q[$];
    logic [6:0] seg_tab [16];
    logic [3:0] mbuf [8];
    int         mpre;
    logic [2:0] midx;
    logic [7:0] mmask;

    bday_digit_scanner #(.SCAN_DIV(SD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbuf[i] = 4'hF;
        mpre  = 0;
        midx  = 3'd0;
        mmask = 8'h00;
        q.delete();
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare them.
    task automatic step(input logic en, input logic [2:0] a, input logic [3:0] d);
        exp_t       e;
        exp_t       got;
        logic [7:0] mset;
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        e.seg = seg_tab[mbuf[midx]];
        e.an  = 8'h01 << midx;
        mset  = mmask | (en ? (8'h01 << a) : 8'h00);
        e.fd  = (mset == 8'hFF);
        mmask = e.fd ? 8'h00 : mset;
        if (en) mbuf[a] = d;
        if (mpre == SD - 1) begin
            mpre = 0;
            midx = midx + 3'd1;
        end else begin
            mpre = mpre + 1;
        end
        q.push_back(e);
        @(posedge CLK);
        #1;
        wr_en = 1'b0;
        got = q.pop_front();
        check("seg", {25'd0, seg}, {25'd0, got.seg});
        check("an", {24'd0, an}, {24'd0, got.an});
        check("frame_done", {31'd0, frame_done}, {31'd0, got.fd});
        if (frame_done) fd_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_seg", {25'd0, seg}, 32'h00);
        check("rst_an", {24'd0, an}, 32'h01);
        check("rst_fd", {31'd0, frame_done}, 32'h0);
        #1;
        RST = 1'b0;
    endtask

    int         base;
    int         guard;
    logic [3:0] codes [8];

    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B;
        seg_tab[3]  = 7'h4F; seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D;
        seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07; seg_tab[8]  = 7'h7F;
        seg_tab[9]  = 7'h6F;
        for (int i = 10; i < 15; i++) seg_tab[i] = 7'h40;
        seg_tab[15] = 7'h00;

        RST = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        model_reset();
        #2;
        check("init_seg", {25'd0, seg}, 32'h00);
        check("init_an", {24'd0, an}, 32'h01);
        check("init_fd", {31'd0, frame_done}, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Free-running scan after reset, two full rotations.
        idle(2 * 8 * SD + 3);

        // Full birthday frame on consecutive cycles.
        codes = '{4'd1, 4'd9, 4'd9, 4'd9, 4'd0, 4'd5, 4'd1, 4'd2};
        base = fd_seen;
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), codes[i]);
        idle(3);
        check("frame_pulses", fd_seen - base, 1);

        guard = 0;
        while (an !== 8'h20 && guard < 64) begin
            step(1'b0, 3'd0, 4'd0);
            guard++;
        end
        check("pos5_reached", {31'd0, an === 8'h20}, 1);
        check("pos5_seg", {25'd0, seg}, 32'h6D);
        idle(8 * SD);

        // Repeated address does not complete a frame.
        base = fd_seen;
        step(1'b1, 3'd3, 4'd3);
        step(1'b1, 3'd3, 4'd8);
        for (int i = 0; i < 3; i++) step(1'b1, 3'(i), 4'(i + 10));
        for (int i = 4; i < 7; i++) step(1'b1, 3'(i), 4'(i));
        idle(4);
        check("no_frame", fd_seen - base, 0);
        step(1'b1, 3'd7, 4'd7);
        idle(2);
        check("frame_after_7", fd_seen - base, 1);

        // Asynchronous reset while the scan is away from position 0.
        guard = 0;
        while (midx != 3'd3 && guard < 64) begin
            step(1'b0, 3'd0, 4'd0);
            guard++;
        end
        check("idx3_reached", {29'd0, midx}, 3);
        async_reset();
        idle(8 * SD + 2);

        // Write to the scanned position: dash, then blank.
        guard = 0;
        while (mpre != 0 && guard < 16) begin
            step(1'b0, 3'd0, 4'd0);
            guard++;
        end
        step(1'b1, midx, 4'hA);
        step(1'b0, 3'd0, 4'd0);
        check("dash_seg", {25'd0, seg}, 32'h40);
        idle(2 * SD);
        guard = 0;
        while (mpre != 0 && guard < 16) begin
            step(1'b0, 3'd0, 4'd0);
            guard++;
        end
        step(1'b1, midx, 4'h7);
        step(1'b0, 3'd0, 4'd0);
        step(1'b1, midx, 4'hF);
        step(1'b0, 3'd0, 4'd0);
        check("blank_seg", {25'd0, seg}, 32'h00);
        idle(3);

        // Partial frame aborted by reset, then a fresh full frame.
        base = fd_seen;
        for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 4'(i + 1));
        async_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 3'(7 - i), 4'(i));
        check("no_early_pulse", fd_seen - base, 0);
        step(1'b1, 3'd0, 4'd9);
        step(1'b0, 3'd0, 4'd0);
        check("pulse_after_8th", {31'd0, fd_seen - base == 1}, 1);
        idle(8 * SD);
        check("single_pulse", fd_seen - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
